argmax_classifier_fix13: RTL and testbench

- Downstream stage of the sigmoid fix13 inference top.
- After the network asserts done, it scans the 10 output neurons through the top's out_idx/out select port and finds the winning digit (argmax) and the winning margin.
- Compares the winner against a supplied label and keeps running correct/total statistics for accuracy measurement on the test set.

---
 rtl/fix13_pkg.sv | 24 ++
 rtl/argmax_classifier_fix13_if.sv | 33 +++
 rtl/top2_tracker.sv | 57 +++++
 rtl/argmax_classifier_fix13.sv | 135 +++++++++++++
 tb/tb_argmax_classifier_fix13.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fix13_pkg.sv
// Shared types and constants for the fix13 inference datapath and its downstream classifier.
package fix13_pkg;

  localparam int DATA_WIDTH  = 13;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_WIDTH   = 4;

  typedef logic signed [DATA_WIDTH-1:0] fix13_t;
  typedef logic [IDX_WIDTH-1:0]         idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_e;

  localparam fix13_t FIX13_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // One extra bit of headroom so max minus second can never wrap.
  function automatic logic [DATA_WIDTH:0] fix13_margin(input fix13_t hi, input fix13_t lo);
    return {hi[DATA_WIDTH-1], hi} - {lo[DATA_WIDTH-1], lo};
  endfunction

endpackage

// File: rtl/argmax_classifier_fix13_if.sv
// Bundle between the argmax classifier, the inference top's neuron-select port and the stats consumer.
interface argmax_classifier_fix13_if #(
  parameter int CNT_WIDTH = 16
) ();
  import fix13_pkg::*;

  logic                 dnn_done;
  idx_t                 label;
  logic                 clr_stats;
  idx_t                 out_idx;
  fix13_t               out_data;
  logic                 busy;
  logic                 result_valid;
  idx_t                 class_out;
  fix13_t               max_out;
  logic [DATA_WIDTH:0]  margin_out;
  logic                 correct;
  logic [CNT_WIDTH-1:0] correct_cnt;
  logic [CNT_WIDTH-1:0] total_cnt;

  modport master (
    input  dnn_done, label, clr_stats, out_data,
    output out_idx, busy, result_valid, class_out, max_out, margin_out,
           correct, correct_cnt, total_cnt
  );

  modport slave (
    output dnn_done, label, clr_stats, out_data,
    input  out_idx, busy, result_valid, class_out, max_out, margin_out,
           correct, correct_cnt, total_cnt
  );

endinterface

// File: rtl/top2_tracker.sv
// Running max / second-max / argmax register. Outputs include the sample presented this cycle,
// so the caller can capture the final result on the same edge as the last sample.
module top2_tracker
  import fix13_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   update_i,
  input  fix13_t data_i,
  input  idx_t   idx_i,
  output fix13_t max_o,
  output fix13_t second_o,
  output idx_t   arg_o
);

  fix13_t max_q, max_d;
  fix13_t second_q, second_d;
  idx_t   arg_q, arg_d;

  // Strict greater-than keeps the lowest index on ties, while an equal value still fills second.
  always_comb begin
    max_d    = max_q;
    second_d = second_q;
    arg_d    = arg_q;
    if (load_i) begin
      max_d    = data_i;
      second_d = FIX13_MIN;
      arg_d    = '0;
    end else if (update_i) begin
      if (data_i > max_q) begin
        second_d = max_q;
        max_d    = data_i;
        arg_d    = idx_i;
      end else if (data_i > second_q) begin
        second_d = data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q    <= '0;
      second_q <= '0;
      arg_q    <= '0;
    end else begin
      max_q    <= max_d;
      second_q <= second_d;
      arg_q    <= arg_d;
    end
  end

  assign max_o    = max_d;
  assign second_o = second_d;
  assign arg_o    = arg_d;

endmodule

// File: rtl/argmax_classifier_fix13.sv
// Scans the inference top's output neurons after done, reports argmax/margin and keeps
// saturating correct/total statistics against a supplied label.
module argmax_classifier_fix13 #(
  parameter int CNT_WIDTH = 16
) (
  input logic                       clk,
  input logic                       rst,
  argmax_classifier_fix13_if.master bus
);
  import fix13_pkg::*;

  localparam idx_t LAST_IDX = idx_t'(NUM_CLASSES - 1);

  state_e state_q, state_d;
  idx_t   idx_q, idx_d;
  idx_t   label_q, label_d;
  logic   done_q;

  idx_t                class_q;
  fix13_t              max_q;
  logic [DATA_WIDTH:0] margin_q;
  logic                correct_q;
  logic [CNT_WIDTH-1:0] correct_cnt_q;
  logic [CNT_WIDTH-1:0] total_cnt_q;

  logic   start;
  logic   load;
  logic   update;
  logic   finish;
  logic   hit;
  fix13_t trk_max;
  fix13_t trk_second;
  idx_t   trk_arg;

  assign start = bus.dnn_done & ~done_q;
  assign hit   = (trk_arg == label_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    label_d = label_q;
    load    = 1'b0;
    update  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          label_d = bus.label;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        load   = (idx_q == '0);
        update = (idx_q != '0);
        if (idx_q == LAST_IDX) begin
          finish  = 1'b1;
          idx_d   = '0;
          state_d = REPORT;
        end else begin
          idx_d = idx_q + idx_t'(1);
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      label_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      label_q <= label_d;
      done_q  <= bus.dnn_done;
    end
  end

  top2_tracker u_tracker (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .update_i (update),
    .data_i   (bus.out_data),
    .idx_i    (idx_q),
    .max_o    (trk_max),
    .second_o (trk_second),
    .arg_o    (trk_arg)
  );

  // Results are captured on the edge that enters REPORT so they line up with result_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      class_q   <= '0;
      max_q     <= '0;
      margin_q  <= '0;
      correct_q <= 1'b0;
    end else if (finish) begin
      class_q   <= trk_arg;
      max_q     <= trk_max;
      margin_q  <= fix13_margin(trk_max, trk_second);
      correct_q <= hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      correct_cnt_q <= '0;
      total_cnt_q   <= '0;
    end else if (bus.clr_stats) begin
      correct_cnt_q <= '0;
      total_cnt_q   <= '0;
    end else if (finish) begin
      if (!(&total_cnt_q))
        total_cnt_q <= total_cnt_q + CNT_WIDTH'(1);
      if (hit && !(&correct_cnt_q))
        correct_cnt_q <= correct_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.out_idx      = (state_q == SCAN) ? idx_q : '0;
  assign bus.busy         = (state_q == SCAN);
  assign bus.result_valid = (state_q == REPORT);
  assign bus.class_out    = class_q;
  assign bus.max_out      = max_q;
  assign bus.margin_out   = margin_q;
  assign bus.correct      = correct_q;
  assign bus.correct_cnt  = correct_cnt_q;
  assign bus.total_cnt    = total_cnt_q;

endmodule

// File: tb/tb_argmax_classifier_fix13.sv
// Self-checking bench for argmax_classifier_fix13: directed table, randomized runs against a
// plain argmax model, and hand-written sequences for held done, mid-scan reset and saturation.
module tb_argmax_classifier_fix13;
  import fix13_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  argmax_classifier_fix13_if bus ();
  argmax_classifier_fix13_if #(.CNT_WIDTH(4)) satBus ();

  argmax_classifier_fix13 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  argmax_classifier_fix13 #(.CNT_WIDTH(4)) satDut (
    .clk (clk),
    .rst (rst),
    .bus (satBus)
  );

  int neuron[16];
  always_comb bus.out_data    = fix13_t'(neuron[bus.out_idx]);
  always_comb satBus.out_data = fix13_t'(10 * (int'(satBus.out_idx) + 1));

  typedef struct {
    int vals[10];
    int lbl;
    int expClass;
    int expMax;
    int expMargin;
    bit expCorrect;
  } vec_t;

  typedef struct packed {
    int cls;
    int maxv;
    int margin;
  } ref_t;

  int vectors     = 0;
  int miscompares = 0;
  int expTotal    = 0;
  int expCorrect  = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Argmax is the first index holding the largest value; second is the best of all the others.
  function automatic ref_t refClassify(input int v[10]);
    ref_t r;
    int second;
    r.maxv = v[0];
    r.cls  = 0;
    for (int i = 1; i < 10; i++)
      if (v[i] > r.maxv) begin
        r.maxv = v[i];
        r.cls  = i;
      end
    second = -(1 << 30);
    for (int j = 0; j < 10; j++)
      if (j != r.cls && v[j] > second) second = v[j];
    r.margin = r.maxv - second;
    return r;
  endfunction

  function automatic vec_t makeVec(input int v[10], input int lbl);
    vec_t x;
    ref_t r;
    r = refClassify(v);
    x.vals       = v;
    x.lbl        = lbl;
    x.expClass   = r.cls;
    x.expMax     = r.maxv;
    x.expMargin  = r.margin;
    x.expCorrect = (r.cls == lbl);
    return x;
  endfunction

  task automatic applyStimulus(input int vals[10], input int lbl, input bit clrInReport,
                               output int latency, output int busyCycles);
    for (int i = 0; i < 10; i++) neuron[i] = vals[i];
    @(negedge clk);
    bus.label    = idx_t'(lbl);
    bus.dnn_done = 1'b1;
    latency      = 0;
    busyCycles   = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.result_valid) begin
        latency = n;
        break;
      end
      if (bus.busy) busyCycles++;
    end
    bus.dnn_done  = 1'b0;
    bus.clr_stats = clrInReport;
  endtask

  task automatic runVector(input vec_t v, input bit clr, input string tag);
    int lat;
    int bc;
    applyStimulus(v.vals, v.lbl, clr, lat, bc);
    expTotal++;
    if (v.expCorrect) expCorrect++;
    checkOutput({tag, " latency"}, lat, 11);
    checkOutput({tag, " busy cycles"}, bc, 10);
    checkOutput({tag, " class_out"}, bus.class_out, v.expClass);
    checkOutput({tag, " max_out"}, int'(bus.max_out), v.expMax);
    checkOutput({tag, " margin_out"}, bus.margin_out, v.expMargin);
    checkOutput({tag, " correct"}, bus.correct, v.expCorrect);
    checkOutput({tag, " correct_cnt"}, bus.correct_cnt, expCorrect);
    checkOutput({tag, " total_cnt"}, bus.total_cnt, expTotal);
    @(posedge clk);
    #1;
    bus.clr_stats = 1'b0;
    if (clr) begin
      expTotal   = 0;
      expCorrect = 0;
    end
    checkOutput({tag, " single pulse"}, bus.result_valid, 0);
    checkOutput({tag, " class held"}, bus.class_out, v.expClass);
    checkOutput({tag, " correct_cnt after"}, bus.correct_cnt, expCorrect);
    checkOutput({tag, " total_cnt after"}, bus.total_cnt, expTotal);
  endtask

  task automatic satRun(input bit clr, output bit seen, output int cls,
                        output int ccDuring, output int tcDuring);
    seen = 1'b0;
    cls  = -1;
    ccDuring = -1;
    tcDuring = -1;
    @(negedge clk);
    satBus.label    = 4'd9;
    satBus.dnn_done = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (satBus.result_valid) begin
        seen     = 1'b1;
        cls      = int'(satBus.class_out);
        ccDuring = int'(satBus.correct_cnt);
        tcDuring = int'(satBus.total_cnt);
        break;
      end
    end
    satBus.dnn_done  = 1'b0;
    satBus.clr_stats = clr;
    @(posedge clk);
    #1;
    satBus.clr_stats = 1'b0;
  endtask

  function automatic int randVal(input int mode);
    case (mode)
      0:       return int'($urandom_range(0, 8191)) - 4096;
      1:       return int'($urandom_range(0, 6)) - 3;
      default: return ($urandom_range(0, 1) == 0) ? -4096 : 4095;
    endcase
  endfunction

  initial begin
    vec_t vecTable[3];
    vec_t v;
    int   vals[10];
    int   lbl;
    int   mode;
    int   pulses;
    int   seenCls;
    bit   found;
    bit   seen;
    int   cls;
    int   ccd;
    int   tcd;
    ref_t r;

    for (int i = 0; i < 10; i++) vecTable[0].vals[i] = 10 * (i + 1);
    vecTable[0].lbl = 9;  vecTable[0].expClass = 9; vecTable[0].expMax = 100;
    vecTable[0].expMargin = 10; vecTable[0].expCorrect = 1'b1;
    for (int i = 0; i < 10; i++) vecTable[1].vals[i] = -4096;
    vecTable[1].vals[3] = -4095;
    vecTable[1].lbl = 2;  vecTable[1].expClass = 3; vecTable[1].expMax = -4095;
    vecTable[1].expMargin = 1; vecTable[1].expCorrect = 1'b0;
    for (int i = 0; i < 10; i++) vecTable[2].vals[i] = 0;
    vecTable[2].vals[2] = 4095;
    vecTable[2].vals[7] = 4095;
    vecTable[2].lbl = 2;  vecTable[2].expClass = 2; vecTable[2].expMax = 4095;
    vecTable[2].expMargin = 0; vecTable[2].expCorrect = 1'b1;

    bus.dnn_done     = 1'b0;
    bus.label        = '0;
    bus.clr_stats    = 1'b0;
    satBus.dnn_done  = 1'b0;
    satBus.label     = '0;
    satBus.clr_stats = 1'b0;

    // Reset state with the reset held asserted across edges.
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset out_idx", bus.out_idx, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset result_valid", bus.result_valid, 0);
    checkOutput("reset class_out", bus.class_out, 0);
    checkOutput("reset max_out", int'(bus.max_out), 0);
    checkOutput("reset margin_out", bus.margin_out, 0);
    checkOutput("reset correct", bus.correct, 0);
    checkOutput("reset correct_cnt", bus.correct_cnt, 0);
    checkOutput("reset total_cnt", bus.total_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);

    $display("[TB] directed table");
    for (int t = 0; t < 3; t++) runVector(vecTable[t], 1'b0, $sformatf("table%0d", t));

    $display("[TB] randomized runs");
    for (int k = 0; k < 20; k++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 10; i++) vals[i] = randVal(mode);
      lbl = int'($urandom_range(0, 9));
      v = makeVec(vals, lbl);
      runVector(v, (k == 10), $sformatf("rand%0d", k));
    end

    $display("[TB] done held high with a second edge inside SCAN");
    for (int i = 0; i < 10; i++) vals[i] = randVal(0);
    lbl = int'($urandom_range(0, 9));
    r = refClassify(vals);
    for (int i = 0; i < 10; i++) neuron[i] = vals[i];
    @(negedge clk);
    bus.label    = idx_t'(lbl);
    bus.dnn_done = 1'b1;
    pulses  = 0;
    seenCls = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (bus.result_valid) begin
        pulses++;
        seenCls = int'(bus.class_out);
      end
      if (n == 4)  bus.dnn_done = 1'b0;
      if (n == 5)  bus.dnn_done = 1'b1;
      if (n == 55) bus.dnn_done = 1'b0;
    end
    expTotal++;
    if (r.cls == lbl) expCorrect++;
    checkOutput("held pulses", pulses, 1);
    checkOutput("held class_out", seenCls, r.cls);
    checkOutput("held total_cnt", bus.total_cnt, expTotal);
    checkOutput("held correct_cnt", bus.correct_cnt, expCorrect);

    $display("[TB] reset in the middle of a scan");
    for (int i = 0; i < 10; i++) neuron[i] = 10 * (i + 1);
    @(negedge clk);
    bus.label    = 4'd9;
    bus.dnn_done = 1'b1;
    found = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.busy && bus.out_idx == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("midreset reached idx5", found, 1);
    rst = 1'b0;
    bus.dnn_done = 1'b0;
    #1;
    expTotal   = 0;
    expCorrect = 0;
    checkOutput("midreset out_idx", bus.out_idx, 0);
    checkOutput("midreset busy", bus.busy, 0);
    checkOutput("midreset result_valid", bus.result_valid, 0);
    checkOutput("midreset class_out", bus.class_out, 0);
    checkOutput("midreset max_out", int'(bus.max_out), 0);
    checkOutput("midreset margin_out", bus.margin_out, 0);
    checkOutput("midreset correct", bus.correct, 0);
    checkOutput("midreset total_cnt", bus.total_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk);
      #1;
      if (bus.result_valid) pulses++;
    end
    checkOutput("midreset no pulse", pulses, 0);
    for (int i = 0; i < 10; i++) vals[i] = randVal(0);
    v = makeVec(vals, int'($urandom_range(0, 9)));
    runVector(v, 1'b0, "post-reset");

    $display("[TB] counter saturation on a 4-bit instance");
    for (int k = 0; k < 15; k++) begin
      satRun(1'b0, seen, cls, ccd, tcd);
      checkOutput($sformatf("sat run%0d seen", k), seen, 1);
    end
    checkOutput("sat fill total_cnt", satBus.total_cnt, 15);
    checkOutput("sat fill correct_cnt", satBus.correct_cnt, 15);
    satRun(1'b0, seen, cls, ccd, tcd);
    checkOutput("sat hold total during", tcd, 15);
    checkOutput("sat hold correct during", ccd, 15);
    checkOutput("sat hold total_cnt", satBus.total_cnt, 15);
    checkOutput("sat hold correct_cnt", satBus.correct_cnt, 15);
    satRun(1'b1, seen, cls, ccd, tcd);
    checkOutput("sat clr seen", seen, 1);
    checkOutput("sat clr class_out", cls, 9);
    checkOutput("sat clr correct", satBus.correct, 1);
    checkOutput("sat clr total_cnt", satBus.total_cnt, 0);
    checkOutput("sat clr correct_cnt", satBus.correct_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
